// File: rtl/bhtbtb_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bhtbtb_table_pkg
// Purpose  : Shared types, constants and helpers for the BHT/BTB storage
//            table and its update pipeline.
// Contents : entry_t       - one table entry (valid, tag, 16 counters, target)
//            CNT_INIT      - counter value written on allocation / clear
//            SLOT_NUM      - counters per fetch block
//            BLK_OFF_W     - fetch-block byte-offset width
//            sat_cnt_upd() - 2-bit saturating counter step
// Revision : 1.0 - initial release
// ============================================================================
package bhtbtb_table_pkg;

    localparam int         SLOT_NUM  = 16;
    localparam int         SLOT_W    = 4;
    localparam int         BLK_OFF_W = 6;
    localparam int         ENT_TAG_W = 16;
    localparam int         TGT_W     = 32;
    localparam logic [1:0] CNT_INIT  = 2'b01;

    typedef struct packed {
        logic                     valid;
        logic [ENT_TAG_W-1:0]     tag;
        logic [SLOT_NUM-1:0][1:0] cnt;
        logic [TGT_W-1:0]         target;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Saturating step: 11 stays 11 on taken, 00 stays 00 on not-taken.
    function automatic logic [1:0] sat_cnt_upd(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) begin
                res = cnt + 2'd1;
            end
        end else begin
            if (cnt != 2'b00) begin
                res = cnt - 2'd1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bhtbtb_table_upd.sv
`default_nettype none
// ============================================================================
// Module   : bhtbtb_upd_pipe
// Purpose  : Two-stage read-modify-write pipeline that trains the table from
//            backend branch resolutions. U1 captures the request and the
//            entry read from the array (forwarded from U2 when U2 is writing
//            the same index); U2 computes the new entry and issues the write.
// Ports    : clock, reset_n       - clock, synchronous active-low reset
//            accept               - update handshake completed this cycle
//            upd_pc/taken/target  - resolved branch information
//            arr_rd_entry         - array contents at the U1 index
//            wr_en/wr_idx/wr_entry- U2 write port towards the array
// Revision : 1.0 - initial release
// ============================================================================
module bhtbtb_upd_pipe #(
    parameter int         IDX_W    = 6,
    parameter int         TAG_W    = 16,
    parameter logic [1:0] CNT_INIT = bhtbtb_table_pkg::CNT_INIT
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 accept,
    input  logic [63:0]                          upd_pc,
    input  logic                                 upd_taken,
    input  logic [31:0]                          upd_target,
    input  logic [bhtbtb_table_pkg::ENTRY_W-1:0] arr_rd_entry,
    output logic                                 wr_en,
    output logic [IDX_W-1:0]                     wr_idx,
    output logic [bhtbtb_table_pkg::ENTRY_W-1:0] wr_entry
);
    import bhtbtb_table_pkg::*;

    localparam int PC_LO  = 2;
    localparam int PC_HI  = BLK_OFF_W + IDX_W + TAG_W - 1;
    localparam int IDX_LO = BLK_OFF_W;
    localparam int TAG_LO = BLK_OFF_W + IDX_W;

    // U1 -> U2 registers
    logic             r_vld;
    logic             r_taken;
    logic [PC_HI:PC_LO] r_pc;
    logic [31:0]      r_target;
    entry_t           r_ent;

    logic [IDX_W-1:0] w_acc_idx;
    entry_t           w_u1_ent;
    entry_t           w_wr_ent;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_u2_idx;
    logic [TAG_W-1:0] w_u2_tag;
    logic [SLOT_W-1:0] w_u2_slot;
    logic             w_u2_hit;

    // Byte-offset and upper PC bits never influence the table.
    logic w_unused_pc;
    assign w_unused_pc = ^{upd_pc[63:PC_HI+1], upd_pc[PC_LO-1:0]};

    assign w_acc_idx = upd_pc[IDX_LO +: IDX_W];

    // A U2 write to the same index lands at the same edge U1 captures, so the
    // array copy is stale; take the in-flight write data instead.
    assign w_u1_ent = (w_wr_en && (w_u2_idx == w_acc_idx)) ? w_wr_ent : entry_t'(arr_rd_entry);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_vld    <= 1'b0;
            r_taken  <= 1'b0;
            r_pc     <= '0;
            r_target <= '0;
            r_ent    <= '0;
        end else begin
            r_vld <= accept;
            if (accept) begin
                r_taken  <= upd_taken;
                r_pc     <= upd_pc[PC_HI:PC_LO];
                r_target <= upd_target;
                r_ent    <= w_u1_ent;
            end
        end
    end

    assign w_u2_idx  = r_pc[IDX_LO +: IDX_W];
    assign w_u2_tag  = r_pc[TAG_LO +: TAG_W];
    assign w_u2_slot = r_pc[BLK_OFF_W-1:PC_LO];
    assign w_u2_hit  = r_ent.valid && (r_ent.tag[TAG_W-1:0] == w_u2_tag);

    // U2 next-entry computation. Misses only allocate on taken branches.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_ent = r_ent;
        if (r_vld) begin
            if (w_u2_hit) begin
                w_wr_en = 1'b1;
                w_wr_ent.cnt[w_u2_slot] = sat_cnt_upd(r_ent.cnt[w_u2_slot], r_taken);
                if (r_taken) begin
                    w_wr_ent.target = r_target;
                end
            end else if (r_taken) begin
                w_wr_en                 = 1'b1;
                w_wr_ent.valid          = 1'b1;
                w_wr_ent.tag            = '0;
                w_wr_ent.tag[TAG_W-1:0] = w_u2_tag;
                w_wr_ent.cnt            = {SLOT_NUM{CNT_INIT}};
                w_wr_ent.cnt[w_u2_slot] = 2'b10;
                w_wr_ent.target         = r_target;
            end
        end
    end

    assign wr_en    = w_wr_en;
    assign wr_idx   = w_u2_idx;
    assign wr_entry = w_wr_ent;

endmodule
`default_nettype wire

// File: rtl/bhtbtb_table.sv
`default_nettype none
// ============================================================================
// Module   : bhtbtb_table
// Purpose  : BHT/BTB storage table feeding the decoder. Holds per-block
//            2-bit counters, a target and a tag per entry; provides a
//            registered 1-cycle lookup, a 2-stage training pipeline and a
//            post-reset clearing sequence.
// Ports    : clock, reset_n      - clock, synchronous active-low reset
//            lkp_valid, lkp_pc   - lookup request
//            rd_valid, bht_rd_data, btb_rd_data, btbtag_hit, bhtbtb2dec_pc
//                                - registered lookup result
//            upd_valid/ready, upd_pc, upd_taken, upd_target
//                                - branch resolution training interface
//            init_done           - table cleared and usable
// Options  : BHTBTB_WR_BYPASS_EN - when defined, a lookup colliding with the
//            U2 write index returns the data being written.
// Revision : 1.0 - initial release
// ============================================================================
module bhtbtb_table #(
    parameter int         IDX_W    = 6,
    parameter int         TAG_W    = 16,
    parameter logic [1:0] CNT_INIT = bhtbtb_table_pkg::CNT_INIT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        lkp_valid,
    input  logic [63:0] lkp_pc,
    output logic        rd_valid,
    output logic [31:0] bht_rd_data,
    output logic [31:0] btb_rd_data,
    output logic        btbtag_hit,
    output logic [63:0] bhtbtb2dec_pc,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [63:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        init_done
);
    import bhtbtb_table_pkg::*;

    localparam int DEPTH  = 1 << IDX_W;
    localparam int IDX_LO = BLK_OFF_W;
    localparam int TAG_LO = BLK_OFF_W + IDX_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_init_cnt;
    logic [IDX_W-1:0] w_init_cnt_nxt;
    logic             w_init_wr;
    logic             w_run;

    entry_t           r_mem [DEPTH];
    entry_t           w_clr_ent;

    logic             w_accept;
    entry_t           w_upd_rd_ent;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    entry_t           w_wr_ent;

    logic [IDX_W-1:0] w_lkp_idx;
    entry_t           w_lkp_arr;
    entry_t           w_lkp_ent;
    entry_t           w_lkp_sel;
    logic             w_lkp_hit;

    // Cleared entry: invalid, every counter weakly not-taken, target zero.
    always_comb begin
        w_clr_ent     = '0;
        w_clr_ent.cnt = {SLOT_NUM{CNT_INIT}};
    end

    // ------------------------------------------------------------------
    // Init / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_init_wr      = 1'b0;
        w_run          = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_wr      = 1'b1;
                w_init_cnt_nxt = r_init_cnt + IDX_W'(1);
                if (r_init_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign init_done = w_run;
    assign upd_ready = w_run;
    assign w_accept  = upd_valid && w_run;

    // ------------------------------------------------------------------
    // Update pipeline
    // ------------------------------------------------------------------
    assign w_upd_rd_ent = r_mem[upd_pc[IDX_LO +: IDX_W]];

    bhtbtb_upd_pipe #(
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .CNT_INIT (CNT_INIT)
    ) u_upd_pipe (
        .clock        (clock),
        .reset_n      (reset_n),
        .accept       (w_accept),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .arr_rd_entry (w_upd_rd_ent),
        .wr_en        (w_wr_en),
        .wr_idx       (w_wr_idx),
        .wr_entry     (w_wr_ent)
    );

    // Single write port: the clearing sequence owns it during INIT, and the
    // update pipeline is empty then because no update can be accepted.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (w_init_wr) begin
                r_mem[r_init_cnt] <= w_clr_ent;
            end else if (w_wr_en) begin
                r_mem[w_wr_idx] <= w_wr_ent;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    assign w_lkp_idx = lkp_pc[IDX_LO +: IDX_W];
    assign w_lkp_arr = r_mem[w_lkp_idx];

`ifdef BHTBTB_WR_BYPASS_EN
    assign w_lkp_ent = (w_wr_en && (w_wr_idx == w_lkp_idx)) ? w_wr_ent : w_lkp_arr;
`else
    assign w_lkp_ent = w_lkp_arr;
`endif

    // Until clearing completes the array may hold stale contents, so lookups
    // report the cleared entry rather than whatever is stored.
    assign w_lkp_sel = w_run ? w_lkp_ent : w_clr_ent;
    assign w_lkp_hit = w_run && w_lkp_sel.valid &&
                       (w_lkp_sel.tag[TAG_W-1:0] == lkp_pc[TAG_LO +: TAG_W]);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_valid      <= 1'b0;
            btbtag_hit    <= 1'b0;
            bht_rd_data   <= '0;
            btb_rd_data   <= '0;
            bhtbtb2dec_pc <= '0;
        end else begin
            rd_valid   <= lkp_valid;
            btbtag_hit <= lkp_valid && w_lkp_hit;
            if (lkp_valid) begin
                bht_rd_data   <= w_lkp_sel.cnt;
                btb_rd_data   <= w_lkp_sel.target;
                bhtbtb2dec_pc <= lkp_pc;
            end
        end
    end

endmodule
`default_nettype wire
